// File: rtl/grad_mem_pkg.sv
// Shared types and helpers for the gradient write path: default widths,
// the buffer entry record and the saturating signed add used by merges.
package grad_mem_pkg;

   localparam int ADDR_WIDTH_DEFAULT  = 32;
   localparam int VALUE_WIDTH_DEFAULT = 16;

   typedef struct packed {
      logic [ADDR_WIDTH_DEFAULT-1:0]         addr;
      logic signed [VALUE_WIDTH_DEFAULT-1:0] value;
      logic                                  valid;
   } wr_entry_t;

   localparam wr_entry_t EMPTY_ENTRY = '{
      addr:  {ADDR_WIDTH_DEFAULT{1'b0}},
      value: {VALUE_WIDTH_DEFAULT{1'b0}},
      valid: 1'b0
   };

   // Overflow shows up as the two top bits of the widened sum disagreeing.
   function automatic logic signed [VALUE_WIDTH_DEFAULT-1:0] sat_add_s(
      input logic signed [VALUE_WIDTH_DEFAULT-1:0] a,
      input logic signed [VALUE_WIDTH_DEFAULT-1:0] b
   );
      logic [VALUE_WIDTH_DEFAULT:0] sum;
      sum = {a[VALUE_WIDTH_DEFAULT-1], a} + {b[VALUE_WIDTH_DEFAULT-1], b};
      if (sum[VALUE_WIDTH_DEFAULT] != sum[VALUE_WIDTH_DEFAULT-1]) begin
         if (sum[VALUE_WIDTH_DEFAULT]) begin
            return {1'b1, {(VALUE_WIDTH_DEFAULT-1){1'b0}}};
         end else begin
            return {1'b0, {(VALUE_WIDTH_DEFAULT-1){1'b1}}};
         end
      end else begin
         return sum[VALUE_WIDTH_DEFAULT-1:0];
      end
   endfunction

endpackage

// File: rtl/gradient_addr_match.sv
// Address compare across all buffered entries, head excluded, producing a
// one-hot hit vector. Only built when GRAD_COALESCE_MERGE_EN is defined.
module gradient_addr_match
   import grad_mem_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  wr_entry_t                       entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]        head_idx,
   input  logic [ADDR_WIDTH_DEFAULT-1:0]   query_addr,
   output logic [DEPTH-1:0]                hit_onehot,
   output logic                            hit
);

   localparam int PTR_W = $clog2(DEPTH);

   // The head may be leaving this cycle, so it never takes a merge.
   always_comb begin
      hit_onehot = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         hit_onehot[i] = entries[i].valid
                       && (entries[i].addr == query_addr)
                       && (head_idx != PTR_W'(i));
      end
   end

   assign hit = |hit_onehot;

endmodule

// File: rtl/gradient_write_coalescer.sv
// Circular write buffer between the arbiter and the memory controller.
// With GRAD_COALESCE_MERGE_EN defined, repeated addresses merge by saturating add.
module gradient_write_coalescer
   import grad_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
   parameter int VALUE_WIDTH = VALUE_WIDTH_DEFAULT,
   parameter int DEPTH       = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDR_WIDTH-1:0]    in_address,
   input  logic [VALUE_WIDTH-1:0]   in_value,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [ADDR_WIDTH-1:0]    wr_address,
   output logic [VALUE_WIDTH-1:0]   wr_value,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [31:0]              merge_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wr_entry_t          entries_q [DEPTH];
   wr_entry_t          entries_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   occ_q, occ_d;
   wr_entry_t          head_entry_s;
   logic               accept_s;
   logic               pop_s;
   logic               merge_s;
   logic               alloc_s;

   // Ready depends on the registered count only, never on wr_ready.
   assign in_ready     = (occ_q < CNT_W'(DEPTH));
   assign wr_valid     = (occ_q != {CNT_W{1'b0}});
   assign head_entry_s = entries_q[head_q];
   assign wr_address   = head_entry_s.valid ? head_entry_s.addr  : {ADDR_WIDTH{1'b0}};
   assign wr_value     = head_entry_s.valid ? head_entry_s.value : {VALUE_WIDTH{1'b0}};
   assign occupancy    = occ_q;
   assign accept_s     = in_valid && in_ready;
   assign pop_s        = wr_valid && wr_ready;

`ifdef GRAD_COALESCE_MERGE_EN
   logic [DEPTH-1:0]   hit_onehot_s;
   logic               hit_s;
   logic [31:0]        merge_count_q, merge_count_d;

   gradient_addr_match #(
      .DEPTH (DEPTH)
   ) u_addr_match (
      .entries    (entries_q),
      .head_idx   (head_q),
      .query_addr (in_address),
      .hit_onehot (hit_onehot_s),
      .hit        (hit_s)
   );

   assign merge_s     = accept_s && hit_s;
   assign merge_count = merge_count_q;
`else
   assign merge_s     = 1'b0;
   assign merge_count = 32'd0;
`endif

   assign alloc_s = accept_s && !merge_s;

   // Next-state: merge/allocate on accept, invalidate head on pop.
   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
`ifdef GRAD_COALESCE_MERGE_EN
      merge_count_d = merge_count_q;
      if (merge_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].value = hit_onehot_s[i]
                               ? sat_add_s(entries_q[i].value, in_value)
                               : entries_q[i].value;
         end
         merge_count_d = merge_count_q + 32'd1;
      end else begin
         merge_count_d = merge_count_q;
      end
`endif
      // Tail never aliases the head while a pop is possible (not empty, not full).
      if (alloc_s) begin
         entries_d[tail_q] = '{addr: in_address, value: in_value, valid: 1'b1};
         tail_d            = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end
      if (pop_s) begin
         entries_d[head_q] = EMPTY_ENTRY;
         head_d            = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end
      occ_d = occ_q + CNT_W'(alloc_s) - CNT_W'(pop_s);
   end

   // State registers; reset drops buffered entries without draining.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= EMPTY_ENTRY;
         end
         head_q <= {PTR_W{1'b0}};
         tail_q <= {PTR_W{1'b0}};
         occ_q  <= {CNT_W{1'b0}};
`ifdef GRAD_COALESCE_MERGE_EN
         merge_count_q <= 32'd0;
`endif
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         occ_q     <= occ_d;
`ifdef GRAD_COALESCE_MERGE_EN
         merge_count_q <= merge_count_d;
`endif
      end
   end

endmodule

// File: tb/tb_gradient_write_coalescer.sv
// Randomised and directed bench for gradient_write_coalescer against a
// queue-based reference model; follows GRAD_COALESCE_MERGE_EN like the design.
module tb_gradient_write_coalescer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_address = 32'd0;
   logic [15:0] in_value = 16'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] wr_address;
   logic [15:0] wr_value;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [3:0]  occupancy;
   logic [31:0] merge_count;

   typedef struct {
      logic [31:0] a;
      int          v;
   } ent_t;

   ent_t        q[$];
   int unsigned mc = 0;
   int          tests_run = 0;
   int          tests_failed = 0;

   gradient_write_coalescer #(.ADDR_WIDTH(32), .VALUE_WIDTH(16), .DEPTH(DEPTH)) dut (
      .clock       (clk),
      .reset       (reset),
      .in_address  (in_address),
      .in_value    (in_value),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .wr_address  (wr_address),
      .wr_value    (wr_value),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .occupancy   (occupancy),
      .merge_count (merge_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int s);
      if (s > 32767) return 32767;
      else if (s < -32768) return -32768;
      else return s;
   endfunction

   // One clock: drive, compare visible state with the model, then advance the model.
   task automatic cycle(input logic v, input logic [31:0] a, input logic [15:0] d, input logic r);
      logic        acc, pop;
      int          idx;
      ent_t        e;
      logic [15:0] exp_val;
      in_valid = v; in_address = a; in_value = d; wr_ready = r;
      #1;
      exp_val = (q.size() != 0) ? 16'(q[0].v) : 16'd0;
      check_eq("wr_valid",    64'(wr_valid),    64'(q.size() != 0));
      check_eq("wr_address",  64'(wr_address),  (q.size() != 0) ? 64'(q[0].a) : 64'd0);
      check_eq("wr_value",    64'(wr_value),    64'(exp_val));
      check_eq("in_ready",    64'(in_ready),    64'(q.size() < DEPTH));
      check_eq("occupancy",   64'(occupancy),   64'(q.size()));
      check_eq("merge_count", 64'(merge_count), 64'(mc));
      acc = v && (q.size() < DEPTH);
      pop = (q.size() != 0) && r;
      @(posedge clk);
      idx = -1;
      if (acc) begin
`ifdef GRAD_COALESCE_MERGE_EN
         for (int i = 1; i < q.size(); i++) if (q[i].a == a) idx = i;
`endif
         if (idx >= 0) begin
            q[idx].v = sat16(q[idx].v + int'($signed(d)));
            mc++;
         end else begin
            e.a = a; e.v = int'($signed(d));
            q.push_back(e);
         end
      end
      if (pop) void'(q.pop_front());
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; in_valid = 1'b0; wr_ready = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      mc = 0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 16'd0, 1'b1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [15:0] rd;
      do_reset(2);

      // Single push shows up one cycle later, then drains.
      cycle(1'b1, 32'h100, 16'd5, 1'b1);
      check_eq("t1_wr_addr", 64'(wr_address), 64'h100);
      drain(2);

      // Merge behind a stalled head.
      cycle(1'b1, 32'h200, 16'd3, 1'b0);
      cycle(1'b1, 32'h300, 16'd1, 1'b0);
      cycle(1'b1, 32'h300, 16'd4, 1'b0);
      cycle(1'b0, 32'd0, 16'd0, 1'b0);
`ifdef GRAD_COALESCE_MERGE_EN
      check_eq("t2_occ", 64'(occupancy), 64'd2);
`else
      check_eq("t2_occ", 64'(occupancy), 64'd3);
`endif
      drain(4);

      // Head excluded from matching; positive and negative saturation.
      cycle(1'b1, 32'h40, 16'd32000, 1'b0);
      cycle(1'b1, 32'h80, 16'd0, 1'b0);
      cycle(1'b1, 32'h40, 16'd100, 1'b0);
      cycle(1'b0, 32'd0, 16'd0, 1'b0);
      check_eq("t3_head_val", 64'(wr_value), 64'd32000);
      cycle(1'b1, 32'h80, 16'd30000, 1'b0);
      cycle(1'b1, 32'h80, 16'd5000, 1'b0);
      drain(5);
      cycle(1'b1, 32'hC0, 16'd1, 1'b0);
      cycle(1'b1, 32'h80, 16'h8000, 1'b0);
      cycle(1'b1, 32'h80, 16'h8000, 1'b0);
      cycle(1'b1, 32'h80, 16'h8000, 1'b0);
      drain(4);

      // Fill, reject when full, pop frees a slot, sustained flow with wrap.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h500 + 32'(i), 16'(i + 1), 1'b0);
      check_eq("t4_full_ready", 64'(in_ready), 64'd0);
      cycle(1'b1, 32'h501, 16'd9, 1'b0);
      cycle(1'b1, 32'h600, 16'd7, 1'b1);
      cycle(1'b1, 32'h601, 16'd7, 1'b1);
      check_eq("t4_occ7", 64'(occupancy), 64'd7);
      for (int i = 0; i < 20; i++) cycle(1'b1, 32'h1000 + 32'(i), 16'(i), 1'b1);
      drain(DEPTH + 1);

      // Reset with live entries.
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h700 + 32'(i), 16'(i), 1'b0);
      do_reset(1);
      check_eq("t5_wr_valid", 64'(wr_valid), 64'd0);
      drain(3);

      // Random traffic over a small address pool to provoke merges and stalls.
      for (int i = 0; i < 400; i++) begin
         ra = 32'h2000 + 32'($urandom_range(0, 5));
         case ($urandom_range(0, 3))
            0: rd = 16'h7FFF - 16'($urandom_range(0, 3));
            1: rd = 16'h8000 + 16'($urandom_range(0, 3));
            default: rd = 16'($urandom);
         endcase
         if (i == 200) do_reset(1);
         cycle($urandom_range(0, 9) < 7, ra, rd, $urandom_range(0, 9) < 5);
      end
      drain(DEPTH + 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
